// File: rtl/tlp_tx_arb_n.sv
// tlp_tx_arb_n: N-channel TLP transmit arbiter for the PCIe TX path.
// Merges N_CH AXI-Stream TLP sources onto one PCIe core TX interface.
// Each source asks for the output with req and is granted it with ack.
// A grant lasts exactly one packet. A grant whose first beat never arrives
// is revoked after ARB_TIMEOUT idle cycles. The data path is a pure
// combinational mux, so the block adds no latency and holds no data.
module tlp_tx_arb_n #(
    parameter int    N_CH         = 2,
    parameter int    C_DATA_WIDTH = 64,
    parameter int    KEEP_WIDTH   = C_DATA_WIDTH / 8,
    parameter string MODE         = "RR",
    parameter int    ARB_TIMEOUT  = 256,
    parameter int    GW           = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                         pcie_clk,
    input  logic                         pcie_rst,
    input  logic [N_CH-1:0]              pcie_txi_req,
    output logic [N_CH-1:0]              pcie_txi_ack,
    output logic [N_CH-1:0]              pcie_txi_tready,
    input  logic [N_CH-1:0]              pcie_txi_tvalid,
    input  logic [N_CH-1:0]              pcie_txi_tlast,
    input  logic [N_CH*KEEP_WIDTH-1:0]   pcie_txi_tkeep,
    input  logic [N_CH*C_DATA_WIDTH-1:0] pcie_txi_tdata,
    input  logic [N_CH*4-1:0]            pcie_txi_tuser,
    input  logic                         pcie_tx_tready,
    output logic                         pcie_tx_tvalid,
    output logic                         pcie_tx_tlast,
    output logic [KEEP_WIDTH-1:0]        pcie_tx_tkeep,
    output logic [C_DATA_WIDTH-1:0]      pcie_tx_tdata,
    output logic [3:0]                   pcie_tx_tuser,
    output logic                         grant_valid,
    output logic [GW-1:0]                grant_id,
    output logic                         arb_timeout
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    localparam bit IS_FIXED = (MODE == "FIXED");
    localparam bit TO_EN    = (ARB_TIMEOUT > 0);
    localparam int CW       = (ARB_TIMEOUT > 1) ? $clog2(ARB_TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = TO_EN ? CW'(ARB_TIMEOUT - 1) : '0;

    logic [0:0]    state_q, state_d;
    logic [GW-1:0] grant_id_q, grant_id_d;
    logic [GW-1:0] last_id_q, last_id_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          started_q, started_d;
    logic          arb_timeout_q, arb_timeout_d;

    logic          out_en;
    logic          beat_hs;
    logic [GW-1:0] winner;

    // Fixed priority scans upward from channel 0. Round-robin scans upward
    // from the channel after the last owner and wraps. The caller only uses
    // the result when at least one req bit is set.
    function automatic logic [GW-1:0] pick_winner(input logic [N_CH-1:0] req,
                                                  input logic [GW-1:0]   last);
        logic [GW-1:0] w;
        logic          found;
        int            idx;
        w     = '0;
        found = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (IS_FIXED) begin
                idx = k;
            end else begin
                idx = int'(last) + 1 + k;
                if (idx >= N_CH) idx = idx - N_CH;
            end
            if (!found && req[idx[GW-1:0]]) begin
                w     = idx[GW-1:0];
                found = 1'b1;
            end
        end
        return w;
    endfunction

    assign winner      = pick_winner(pcie_txi_req, last_id_q);
    assign out_en      = (state_q == ST_XFER) && !pcie_rst;
    assign grant_valid = (state_q == ST_XFER);
    assign grant_id    = grant_id_q;
    assign arb_timeout = arb_timeout_q;
    assign pcie_txi_ack = grant_valid ? (N_CH'(1) << grant_id_q) : '0;
    assign beat_hs     = pcie_tx_tvalid && pcie_tx_tready;

    // Output mux: route the owning channel straight through; everything is quiet when idle or in reset.
    always_comb begin
        pcie_tx_tvalid  = 1'b0;
        pcie_tx_tlast   = 1'b0;
        pcie_tx_tkeep   = '0;
        pcie_tx_tdata   = '0;
        pcie_tx_tuser   = '0;
        pcie_txi_tready = '0;
        if (out_en) begin
            pcie_tx_tvalid  = pcie_txi_tvalid[grant_id_q];
            pcie_tx_tlast   = pcie_txi_tlast[grant_id_q];
            pcie_tx_tkeep   = pcie_txi_tkeep[grant_id_q*KEEP_WIDTH +: KEEP_WIDTH];
            pcie_tx_tdata   = pcie_txi_tdata[grant_id_q*C_DATA_WIDTH +: C_DATA_WIDTH];
            pcie_tx_tuser   = pcie_txi_tuser[grant_id_q*4 +: 4];
            pcie_txi_tready = N_CH'(pcie_tx_tready) << grant_id_q;
        end
    end

    // Ownership control: grant from IDLE, release on tlast handshake or on an unused-grant timeout.
    always_comb begin
        state_d       = state_q;
        grant_id_d    = grant_id_q;
        last_id_d     = last_id_q;
        cnt_d         = cnt_q;
        started_d     = started_q;
        arb_timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|pcie_txi_req) begin
                    state_d    = ST_XFER;
                    grant_id_d = winner;
                    cnt_d      = '0;
                    started_d  = 1'b0;
                end
            end
            ST_XFER: begin
                if (beat_hs && pcie_tx_tlast) begin
                    state_d   = ST_IDLE;
                    last_id_d = grant_id_q;
                end else if (TO_EN && !started_q && !beat_hs && (cnt_q == TO_LAST)) begin
                    state_d       = ST_IDLE;
                    last_id_d     = grant_id_q;
                    arb_timeout_d = 1'b1;
                end else if (beat_hs) begin
                    started_d = 1'b1;
                end else if (TO_EN && !started_q) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any packet in flight and restarts round-robin at channel 0.
    always_ff @(posedge pcie_clk) begin
        if (pcie_rst) begin
            state_q       <= ST_IDLE;
            grant_id_q    <= '0;
            last_id_q     <= GW'(N_CH - 1);
            cnt_q         <= '0;
            started_q     <= 1'b0;
            arb_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_id_q    <= grant_id_d;
            last_id_q     <= last_id_d;
            cnt_q         <= cnt_d;
            started_q     <= started_d;
            arb_timeout_q <= arb_timeout_d;
        end
    end

endmodule

// File: tb/tb_tlp_tx_arb_n.sv
// tb_tlp_tx_arb_n: drives two arbiter instances side by side, one in
// round-robin mode and one in fixed-priority mode, from packet sources
// inside the bench. An arbitration model written from the block's rules
// predicts every output on every cycle. Hand-computed grant orders and
// cycle gaps are then checked against what each instance actually did.
module tb_tlp_tx_arb_n;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int KW = 8;
    localparam int TO = 8;

    logic          pcie_clk = 1'b0;
    logic          pcie_rst;
    logic [N-1:0]    req      [2];
    logic [N-1:0]    ack      [2];
    logic [N-1:0]    txi_rdy  [2];
    logic [N-1:0]    tvalid   [2];
    logic [N-1:0]    tlast    [2];
    logic [N*KW-1:0] tkeep    [2];
    logic [N*DW-1:0] tdata    [2];
    logic [N*4-1:0]  tuser    [2];
    logic            tx_rdy   [2];
    logic            tx_vld   [2];
    logic            tx_last  [2];
    logic [KW-1:0]   tx_keep  [2];
    logic [DW-1:0]   tx_data  [2];
    logic [3:0]      tx_user  [2];
    logic            gv       [2];
    logic [1:0]      gid      [2];
    logic            ato      [2];

    always #5 pcie_clk = ~pcie_clk;

    tlp_tx_arb_n #(.N_CH(N), .C_DATA_WIDTH(DW), .KEEP_WIDTH(KW), .MODE("RR"), .ARB_TIMEOUT(TO)) dut_rr (
        .pcie_clk(pcie_clk), .pcie_rst(pcie_rst),
        .pcie_txi_req(req[0]), .pcie_txi_ack(ack[0]), .pcie_txi_tready(txi_rdy[0]),
        .pcie_txi_tvalid(tvalid[0]), .pcie_txi_tlast(tlast[0]), .pcie_txi_tkeep(tkeep[0]),
        .pcie_txi_tdata(tdata[0]), .pcie_txi_tuser(tuser[0]), .pcie_tx_tready(tx_rdy[0]),
        .pcie_tx_tvalid(tx_vld[0]), .pcie_tx_tlast(tx_last[0]), .pcie_tx_tkeep(tx_keep[0]),
        .pcie_tx_tdata(tx_data[0]), .pcie_tx_tuser(tx_user[0]),
        .grant_valid(gv[0]), .grant_id(gid[0]), .arb_timeout(ato[0])
    );

    tlp_tx_arb_n #(.N_CH(N), .C_DATA_WIDTH(DW), .KEEP_WIDTH(KW), .MODE("FIXED"), .ARB_TIMEOUT(TO)) dut_fx (
        .pcie_clk(pcie_clk), .pcie_rst(pcie_rst),
        .pcie_txi_req(req[1]), .pcie_txi_ack(ack[1]), .pcie_txi_tready(txi_rdy[1]),
        .pcie_txi_tvalid(tvalid[1]), .pcie_txi_tlast(tlast[1]), .pcie_txi_tkeep(tkeep[1]),
        .pcie_txi_tdata(tdata[1]), .pcie_txi_tuser(tuser[1]), .pcie_tx_tready(tx_rdy[1]),
        .pcie_tx_tvalid(tx_vld[1]), .pcie_tx_tlast(tx_last[1]), .pcie_tx_tkeep(tx_keep[1]),
        .pcie_tx_tdata(tx_data[1]), .pcie_tx_tuser(tx_user[1]),
        .grant_valid(gv[1]), .grant_id(gid[1]), .arb_timeout(ato[1])
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit rst_cmd;

    // Packet sources: per instance and channel.
    int pkts_left [2][N];
    int plen      [2][N];
    int beat_no   [2][N];
    int pkt_no    [2][N];
    bit mute      [2][N];
    bit bp_en     [2];
    int bp_idx    [2];
    logic [3:0] bp_pat = 4'b1001;

    // Arbitration model state.
    bit m_fixed   [2] = '{1'b0, 1'b1};
    bit m_valid   [2];
    int m_owner   [2];
    int m_last    [2];
    int m_cnt     [2];
    bit m_started [2];
    bit m_pulse   [2];

    // Observation logs.
    int glog_id  [2][16];
    int glog_cyc [2][16];
    int gcount   [2];
    int pulse_cyc[2];
    int ack_hi   [2][N];
    int beats_out[2];
    int tlast_at [2];
    bit prev_gv  [2];

    task automatic chk(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s inst%0d cyc=%0d got=%0h expected=%0h", name, inst, cyc, act, exp);
        end
    endtask

    function automatic int model_pick(input int i, input logic [N-1:0] r);
        int c;
        for (int k = 1; k <= N; k++) begin
            c = m_fixed[i] ? (k - 1) : ((m_last[i] + k) % N);
            if (r[c]) return c;
        end
        return 0;
    endfunction

    // Drive reset, backpressure and all source signals for the coming cycle.
    task automatic applyStimulus();
        logic rdy;
        pcie_rst = rst_cmd;
        for (int i = 0; i < 2; i++) begin
            rdy = 1'b1;
            if (bp_en[i] && ack[i] != '0 && bp_idx[i] < 4) begin
                rdy = bp_pat[bp_idx[i]];
                bp_idx[i]++;
            end
            tx_rdy[i] = rdy;
            for (int c = 0; c < N; c++) begin
                req[i][c]    = (pkts_left[i][c] > 0);
                tvalid[i][c] = (pkts_left[i][c] > 0) && ack[i][c] && !mute[i][c];
                tlast[i][c]  = (beat_no[i][c] == plen[i][c] - 1);
                tdata[i][c*DW +: DW] = {16'(i), 8'(c), 8'(pkt_no[i][c]), 32'(beat_no[i][c])};
                tkeep[i][c*KW +: KW] = 8'hFF >> c;
                tuser[i][c*4 +: 4]   = 4'(beat_no[i][c]);
            end
        end
    endtask

    // Compare every output of both instances with the model, and log grant events.
    task automatic checkOutput();
        int o;
        bit en;
        for (int i = 0; i < 2; i++) begin
            o  = m_owner[i];
            en = m_valid[i] && !pcie_rst;
            chk("ack", i, 64'(ack[i]), m_valid[i] ? (64'd1 << o) : 64'd0);
            chk("grant_valid", i, 64'(gv[i]), 64'(m_valid[i]));
            if (m_valid[i]) chk("grant_id", i, 64'(gid[i]), 64'(o));
            chk("arb_timeout", i, 64'(ato[i]), 64'(m_pulse[i]));
            chk("tx_tvalid", i, 64'(tx_vld[i]), en ? 64'(tvalid[i][o]) : 64'd0);
            chk("tx_tlast", i, 64'(tx_last[i]), en ? 64'(tlast[i][o]) : 64'd0);
            chk("tx_tkeep", i, 64'(tx_keep[i]), en ? 64'(tkeep[i][o*KW +: KW]) : 64'd0);
            chk("tx_tdata", i, tx_data[i], en ? tdata[i][o*DW +: DW] : 64'd0);
            chk("tx_tuser", i, 64'(tx_user[i]), en ? 64'(tuser[i][o*4 +: 4]) : 64'd0);
            chk("txi_tready", i, 64'(txi_rdy[i]), en ? (64'(tx_rdy[i]) << o) : 64'd0);
            if (gv[i] && !prev_gv[i] && gcount[i] < 16) begin
                glog_id[i][gcount[i]]  = int'(gid[i]);
                glog_cyc[i][gcount[i]] = cyc;
                gcount[i]++;
            end
            prev_gv[i] = gv[i];
            if (ato[i] && pulse_cyc[i] < 0) pulse_cyc[i] = cyc;
            for (int c = 0; c < N; c++) if (ack[i][c]) ack_hi[i][c]++;
            if (tx_vld[i] && tx_rdy[i]) begin
                beats_out[i]++;
                if (tx_last[i] && tlast_at[i] < 0) tlast_at[i] = beats_out[i];
            end
        end
    endtask

    // Advance sources on their handshakes, then step the model across the coming edge.
    task automatic advance();
        int  o;
        bit  hs;
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < N; c++) begin
                if (txi_rdy[i][c] && tvalid[i][c]) begin
                    if (tlast[i][c]) begin
                        pkts_left[i][c]--;
                        beat_no[i][c] = 0;
                        pkt_no[i][c]++;
                    end else begin
                        beat_no[i][c]++;
                    end
                end
            end
            o = m_owner[i];
            if (pcie_rst) begin
                m_valid[i] = 1'b0;
                m_last[i]  = N - 1;
                m_pulse[i] = 1'b0;
            end else if (!m_valid[i]) begin
                m_pulse[i] = 1'b0;
                if (req[i] != '0) begin
                    m_owner[i]   = model_pick(i, req[i]);
                    m_valid[i]   = 1'b1;
                    m_cnt[i]     = 0;
                    m_started[i] = 1'b0;
                end
            end else begin
                hs = tvalid[i][o] && tx_rdy[i];
                if (hs && tlast[i][o]) begin
                    m_valid[i] = 1'b0;
                    m_last[i]  = o;
                    m_pulse[i] = 1'b0;
                end else if (!m_started[i] && !hs && m_cnt[i] == TO - 1) begin
                    m_valid[i] = 1'b0;
                    m_last[i]  = o;
                    m_pulse[i] = 1'b1;
                end else begin
                    m_pulse[i] = 1'b0;
                    if (hs) m_started[i] = 1'b1;
                    else if (!m_started[i]) m_cnt[i]++;
                end
            end
        end
    endtask

    task automatic step();
        @(negedge pcie_clk);
        applyStimulus();
        #3;
        checkOutput();
        advance();
        cyc++;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic clearSources();
        for (int i = 0; i < 2; i++) begin
            bp_en[i]  = 1'b0;
            bp_idx[i] = 0;
            for (int c = 0; c < N; c++) begin
                pkts_left[i][c] = 0;
                plen[i][c]      = 1;
                beat_no[i][c]   = 0;
                pkt_no[i][c]    = 0;
                mute[i][c]      = 1'b0;
            end
        end
    endtask

    task automatic clearLogs();
        for (int i = 0; i < 2; i++) begin
            gcount[i]    = 0;
            pulse_cyc[i] = -1;
            beats_out[i] = 0;
            tlast_at[i]  = -1;
            for (int c = 0; c < N; c++) ack_hi[i][c] = 0;
        end
    endtask

    task automatic doReset();
        clearSources();
        rst_cmd = 1'b1;
        run(2);
        rst_cmd = 1'b0;
        clearLogs();
    endtask

    task automatic setPkt(input int i, input int c, input int n, input int len);
        pkts_left[i][c] = n;
        plen[i][c]      = len;
    endtask

    initial begin
        int exp_rr [5] = '{0, 1, 2, 3, 0};
        int exp_fx [4] = '{0, 0, 0, 3};
        int exp_bp [4] = '{1, 1, 2, 2};
        int waited;

        pcie_rst = 1'b1;
        rst_cmd  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req[i] = '0; tvalid[i] = '0; tlast[i] = '0;
            tkeep[i] = '0; tdata[i] = '0; tuser[i] = '0; tx_rdy[i] = 1'b1;
            m_valid[i] = 1'b0; m_owner[i] = 0; m_last[i] = N - 1;
            m_cnt[i] = 0; m_started[i] = 1'b0; m_pulse[i] = 1'b0; prev_gv[i] = 1'b0;
        end
        clearSources();
        clearLogs();

        // Reset state.
        doReset();
        chk("rst_grant_valid", 0, 64'(gv[0]), 64'd0);
        chk("rst_ack", 1, 64'(ack[1]), 64'd0);

        // Single 3-beat packet on ch2 (RR); two single-beat packets on ch1/ch2 (FIXED).
        setPkt(0, 2, 1, 3);
        setPkt(1, 1, 1, 1);
        setPkt(1, 2, 1, 1);
        run(10);
        chk("s1_ngrant", 0, 64'(gcount[0]), 64'd1);
        chk("s1_gid", 0, 64'(glog_id[0][0]), 64'd2);
        chk("s1_ack_cycles", 0, 64'(ack_hi[0][2]), 64'd3);
        chk("s1_beats", 0, 64'(beats_out[0]), 64'd3);
        chk("s1_tlast_beat", 0, 64'(tlast_at[0]), 64'd3);
        chk("s1_fx_first", 1, 64'(glog_id[1][0]), 64'd1);
        chk("s1_fx_second", 1, 64'(glog_id[1][1]), 64'd2);
        chk("s1_fx_gap", 1, 64'(glog_cyc[1][1] - glog_cyc[1][0]), 64'd2);

        // RR fairness with all four requesting; FIXED starvation of ch3 by ch0.
        doReset();
        setPkt(0, 0, 2, 2);
        for (int c = 1; c < N; c++) setPkt(0, c, 1, 2);
        setPkt(1, 0, 3, 2);
        setPkt(1, 3, 1, 2);
        run(20);
        chk("s2_rr_ngrant", 0, 64'(gcount[0]), 64'd5);
        for (int k = 0; k < 5; k++) chk("s2_rr_order", 0, 64'(glog_id[0][k]), 64'(exp_rr[k]));
        for (int k = 0; k < 4; k++) chk("s2_rr_gap", 0, 64'(glog_cyc[0][k+1] - glog_cyc[0][k]), 64'd3);
        chk("s2_fx_ngrant", 1, 64'(gcount[1]), 64'd4);
        for (int k = 0; k < 4; k++) chk("s2_fx_order", 1, 64'(glog_id[1][k]), 64'(exp_fx[k]));
        for (int k = 0; k < 3; k++) chk("s2_fx_gap", 1, 64'(glog_cyc[1][k+1] - glog_cyc[1][k]), 64'd3);

        // Backpressure 1,0,0,1 on a 4-beat ch1 packet (RR); single-beat packets (FIXED).
        doReset();
        setPkt(0, 1, 1, 4);
        bp_en[0] = 1'b1;
        setPkt(1, 1, 2, 1);
        setPkt(1, 2, 2, 1);
        run(12);
        chk("s3_ngrant", 0, 64'(gcount[0]), 64'd1);
        chk("s3_ack_cycles", 0, 64'(ack_hi[0][1]), 64'd6);
        chk("s3_beats", 0, 64'(beats_out[0]), 64'd4);
        chk("s3_tlast_beat", 0, 64'(tlast_at[0]), 64'd4);
        for (int k = 0; k < 4; k++) chk("s3_fx_order", 1, 64'(glog_id[1][k]), 64'(exp_bp[k]));
        for (int k = 0; k < 3; k++) chk("s3_fx_gap", 1, 64'(glog_cyc[1][k+1] - glog_cyc[1][k]), 64'd2);

        // Timeout: a granted channel that never sends loses the grant after 8 cycles.
        doReset();
        setPkt(0, 1, 1, 2);
        mute[0][1] = 1'b1;
        setPkt(0, 2, 1, 2);
        setPkt(1, 0, 1, 1);
        mute[1][0] = 1'b1;
        setPkt(1, 1, 1, 1);
        run(16);
        chk("s4_first", 0, 64'(glog_id[0][0]), 64'd1);
        chk("s4_next", 0, 64'(glog_id[0][1]), 64'd2);
        chk("s4_pulse_at", 0, 64'(pulse_cyc[0] - glog_cyc[0][0]), 64'd8);
        chk("s4_regrant_gap", 0, 64'(glog_cyc[0][1] - glog_cyc[0][0]), 64'd9);
        chk("s4_fx_first", 1, 64'(glog_id[1][0]), 64'd0);
        chk("s4_fx_next", 1, 64'(glog_id[1][1]), 64'd0);
        chk("s4_fx_pulse_at", 1, 64'(pulse_cyc[1] - glog_cyc[1][0]), 64'd8);

        // Reset on beat 2 of a 5-beat ch1 packet; ch0 must win first afterwards.
        doReset();
        setPkt(0, 1, 1, 5);
        setPkt(1, 1, 1, 5);
        waited = 0;
        while (beat_no[0][1] != 1 && waited < 10) begin
            step();
            waited++;
        end
        chk("s5_reach_beat2", 0, 64'(beat_no[0][1]), 64'd1);
        for (int i = 0; i < 2; i++) begin
            setPkt(i, 0, 1, 1);
            setPkt(i, 3, 1, 1);
        end
        rst_cmd = 1'b1;
        step();
        rst_cmd = 1'b0;
        clearLogs();
        step();
        chk("s5_ack_after", 0, 64'(ack[0]), 64'd0);
        chk("s5_gv_after", 0, 64'(gv[0]), 64'd0);
        chk("s5_tvalid_after", 0, 64'(tx_vld[0]), 64'd0);
        run(8);
        chk("s5_first_after", 0, 64'(glog_id[0][0]), 64'd0);
        chk("s5_fx_first_after", 1, 64'(glog_id[1][0]), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/tlp_tx_arb_n.md
# tlp_tx_arb_n

Parametrised N-channel TLP transmit arbiter for the PCIe TX path. It merges `N_CH` AXI-Stream TLP sources, each using a req/ack ownership handshake, onto the single AXIS TX interface of the PCIe core. Switching is packet-atomic with selectable round-robin or fixed-priority arbitration. A granted source that never starts its packet loses ownership after a programmable timeout. It replaces the fixed two-input mux between the TX engine and the Ethernet-injected TLP path and makes room for further sources (cfg responder, command engine).

## Interface
Parameters:
- `N_CH`, 2: number of input channels (2..16).
- `C_DATA_WIDTH`, 64: AXIS data width.
- `KEEP_WIDTH`, `C_DATA_WIDTH/8`: tkeep width.
- `MODE`, "RR": "RR" selects round-robin; "FIXED" gives channel 0 the highest priority.
- `ARB_TIMEOUT`, 256: cycles a grant may stay idle before the first beat is forced to release; 0 disables the timeout.
- `GW`, `(N_CH>1)?$clog2(N_CH):1`: width of the grant index (derived).

Ports:
- `pcie_clk` in 1: the single clock.
- `pcie_rst` in 1: synchronous, active-high reset.
- `pcie_txi_req` in `N_CH`: per-channel request to own the output.
- `pcie_txi_ack` out `N_CH`: per-channel grant, one-hot or zero.
- `pcie_txi_tready` out `N_CH`: per-channel ready.
- `pcie_txi_tvalid` / `pcie_txi_tlast` in `N_CH`: per-channel valid and last.
- `pcie_txi_tkeep` in `N_CH*KEEP_WIDTH`: channel c occupies slice `[c*KEEP_WIDTH +: KEEP_WIDTH]`.
- `pcie_txi_tdata` in `N_CH*C_DATA_WIDTH`: sliced the same way.
- `pcie_txi_tuser` in `N_CH*4`: sliced the same way.
- `pcie_tx_tready` in 1: ready from the PCIe core.
- `pcie_tx_tvalid` / `pcie_tx_tlast` out 1; `pcie_tx_tkeep` out `KEEP_WIDTH`; `pcie_tx_tdata` out `C_DATA_WIDTH`; `pcie_tx_tuser` out 4: output to the PCIe core.
- `grant_valid` out 1: a channel currently owns the output.
- `grant_id` out `GW`: index of the owning channel.
- `arb_timeout` out 1: one-cycle pulse when a grant is revoked by timeout.

## Operation
- FSM states are IDLE and XFER.
- **IDLE:**
  - All acks are 0, `pcie_tx_tvalid`=0, all `pcie_txi_tready`=0.
  - If any `pcie_txi_req` bit is set, register the winner into `grant_id`, set `grant_valid` and `pcie_txi_ack[winner]`, then go to XFER.
- **Winner selection:**
  - FIXED: lowest set req index wins.
  - RR: the first set req at or after `(last_id+1) mod N_CH`, wrapping.
  - `last_id` updates only when a packet ends or a grant times out.
- **XFER, data path:**
  - The data path is combinational: `pcie_tx_t{valid,last,keep,data,user}` come from slice `grant_id`.
  - `pcie_txi_tready[grant_id]` = `pcie_tx_tready`; every other ready is 0.
- **XFER, ownership:**
  - `pcie_txi_req` is ignored while in XFER. Deasserting it does not release ownership.
  - Ownership ends only on a tlast handshake (`pcie_tx_tvalid & pcie_tx_tready & pcie_tx_tlast`). On that edge: go to IDLE, clear ack and `grant_valid`, and set `last_id <= grant_id`.
- **Timeout:**
  - A counter runs while in XFER and no beat of the packet has handshaked yet.
  - It resets at grant and freezes permanently after the first beat. A mid-packet stall is never timed out.
  - When the count reaches `ARB_TIMEOUT-1` with no handshake that cycle: go to IDLE, pulse `arb_timeout`, and set `last_id <= grant_id`.
- **Single-beat packets:** tlast on the first beat ends ownership normally.

## Timing
- Reset values: state IDLE; `pcie_txi_ack`=0; `grant_valid`=0; `grant_id`=0; `arb_timeout`=0; `last_id`=N_CH-1, so channel 0 wins first in RR.
- Combinational outputs are 0 while in IDLE and during reset.
- Req to ack latency: req seen high at edge k gives ack high from edge k. The first beat may handshake in the same cycle ack is first high.
- End of packet: tlast handshake at edge m gives ack low from edge m. The next grant's ack rises at edge m+1, so there is exactly one idle cycle between packets.
- Zero latency from input to output data; the block holds no data registers.
- Simultaneous requests are resolved by MODE. A req arriving in the cycle ownership ends competes in the next IDLE.
- Reset mid-packet: the packet is abandoned and the state goes to IDLE on the reset edge. Recovery of the partial TLP is not this block's responsibility.
- When `pcie_tx_tready`=0, the granted channel must hold its data stable (AXIS rule); the block adds no buffering.

## Test plan
- **Single channel:** N_CH=4, RR; ch2 sends a 3-beat TLP with tready=1 -> ack[2] is high for 3 cycles, the output carries ch2 data unchanged, and tlast appears on beat 3.
- **RR fairness:** all four reqs held high, each sending 2-beat packets -> grant order 0,1,2,3,0, with one idle cycle between packets.
- **FIXED priority:** MODE="FIXED"; ch0 and ch3 request continuously -> ch3 is never granted and ch0 packets repeat every 3 cycles.
- **Backpressure:** tready toggles 1,0,0,1 during a 4-beat ch1 packet -> ch1 tready mirrors it, no beat is lost or duplicated, and ownership does not change mid-packet.
- **Timeout:** ARB_TIMEOUT=8; ch1 requests but never asserts tvalid -> `arb_timeout` pulses on cycle 8 after the grant and ch2 (pending) is granted next.
- **Reset mid-packet:** `pcie_rst` is asserted on beat 2 of 5 -> the next cycle shows ack=0, tvalid=0, `grant_valid`=0, and after release ch0 wins first.
